// File: rtl/led_pwm_fader_if.sv
// Pattern handshake between a pattern source and the LED PWM fader.
// The source offers PATTERN with PATTERN_VALID; the fader accepts it when PATTERN_READY is high.
interface led_pwm_fader_if;
  logic [7:0] PATTERN;
  logic       PATTERN_VALID;
  logic       PATTERN_READY;

  modport master (output PATTERN, output PATTERN_VALID, input PATTERN_READY);
  modport slave  (input PATTERN, input PATTERN_VALID, output PATTERN_READY);
endinterface

// File: rtl/led_pwm_fader.sv
// Eight-channel PWM LED driver: patterns are accepted at any time but applied at PWM
// period boundaries, and LEDs being switched off either drop at once or fade out.
module led_pwm_fader #(
  parameter int unsigned PWM_BITS = 4,
  parameter int unsigned PRESCALE = 4,
  parameter int unsigned FADE_DIV = 2
) (
  input  logic                CLK,
  input  logic                RST_N,
  led_pwm_fader_if.slave      pat_if,
  input  logic [PWM_BITS-1:0] BRIGHT,
  input  logic                FADE_EN,
  output logic [7:0]          LED,
  output logic                BUSY
);

  localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned FD_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [PWM_BITS-1:0] MAX_LVL = {PWM_BITS{1'b1}};
  localparam logic [PS_W-1:0]     PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [FD_W-1:0]     FD_LAST = FD_W'(FADE_DIV - 1);

  logic [PS_W-1:0]     ps_r, ps_nxt_s;
  logic [PWM_BITS-1:0] pwm_r, pwm_nxt_s;
  logic [FD_W-1:0]     fade_r, fade_nxt_s;
  logic [7:0]          pend_pat_r;
  logic                pend_r, pend_nxt_s;
  logic                ready_r;
  logic [7:0]          tgt_r, tgt_nxt_s;
  logic [PWM_BITS-1:0] lvl_r [8];
  logic [PWM_BITS-1:0] lvl_nxt_s [8];
  logic [7:0]          led_r, led_nxt_s;
  logic [7:0]          off_lit_s;
  logic                ps_wrap_s, boundary_s, fade_wrap_s, xfer_s;

  assign ps_wrap_s   = (ps_r == PS_LAST);
  assign boundary_s  = ps_wrap_s && (pwm_r == MAX_LVL);
  assign fade_wrap_s = boundary_s && (fade_r == FD_LAST);
  assign xfer_s      = pat_if.PATTERN_VALID && ready_r;

  // Prescale, PWM phase and fade-period counters.
  always_comb begin
    ps_nxt_s   = ps_r;
    pwm_nxt_s  = pwm_r;
    fade_nxt_s = fade_r;
    if (ps_wrap_s) begin
      ps_nxt_s  = {PS_W{1'b0}};
      pwm_nxt_s = pwm_r + PWM_BITS'(1);
    end else begin
      ps_nxt_s  = ps_r + PS_W'(1);
      pwm_nxt_s = pwm_r;
    end
    if (!boundary_s) begin
      fade_nxt_s = fade_r;
    end else if (fade_r == FD_LAST) begin
      fade_nxt_s = {FD_W{1'b0}};
    end else begin
      fade_nxt_s = fade_r + FD_W'(1);
    end
  end

  // Pattern handshake: one pending slot, emptied into the target at a period boundary.
  always_comb begin
    tgt_nxt_s  = tgt_r;
    pend_nxt_s = pend_r;
    if (boundary_s && pend_r) begin
      tgt_nxt_s = pend_pat_r;
    end else begin
      tgt_nxt_s = tgt_r;
    end
    if (xfer_s) begin
      pend_nxt_s = 1'b1;
    end else if (boundary_s) begin
      pend_nxt_s = 1'b0;
    end else begin
      pend_nxt_s = pend_r;
    end
  end

  // Per-LED level update and PWM compare against the phase of the coming cycle.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      lvl_nxt_s[i] = lvl_r[i];
      if (!boundary_s) begin
        lvl_nxt_s[i] = lvl_r[i];
      end else if (tgt_nxt_s[i]) begin
        lvl_nxt_s[i] = BRIGHT;
      end else if (!FADE_EN) begin
        lvl_nxt_s[i] = {PWM_BITS{1'b0}};
      end else if (fade_wrap_s && !tgt_r[i] && (lvl_r[i] != {PWM_BITS{1'b0}})) begin
        // an LED whose old target was 1 is newly off and holds for this boundary
        lvl_nxt_s[i] = lvl_r[i] - PWM_BITS'(1);
      end else begin
        lvl_nxt_s[i] = lvl_r[i];
      end
      led_nxt_s[i] = (lvl_nxt_s[i] == MAX_LVL) || (lvl_nxt_s[i] > pwm_nxt_s);
      off_lit_s[i] = !tgt_r[i] && (lvl_r[i] != {PWM_BITS{1'b0}});
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      ps_r       <= {PS_W{1'b0}};
      pwm_r      <= {PWM_BITS{1'b0}};
      fade_r     <= {FD_W{1'b0}};
      pend_pat_r <= 8'h00;
      pend_r     <= 1'b0;
      ready_r    <= 1'b0;
      tgt_r      <= 8'h00;
      led_r      <= 8'h00;
      for (int i = 0; i < 8; i++) begin
        lvl_r[i] <= {PWM_BITS{1'b0}};
      end
    end else begin
      ps_r    <= ps_nxt_s;
      pwm_r   <= pwm_nxt_s;
      fade_r  <= fade_nxt_s;
      pend_r  <= pend_nxt_s;
      ready_r <= !pend_nxt_s;
      tgt_r   <= tgt_nxt_s;
      led_r   <= led_nxt_s;
      lvl_r   <= lvl_nxt_s;
      if (xfer_s) begin
        pend_pat_r <= pat_if.PATTERN;
      end else begin
        pend_pat_r <= pend_pat_r;
      end
    end
  end

  assign pat_if.PATTERN_READY = ready_r;
  assign LED  = led_r;
  assign BUSY = |off_lit_s;

endmodule

// File: tb/tb_led_pwm_fader.sv
// Bench for led_pwm_fader: a cycle-count based reference model checked every cycle,
// directed scenarios with hand-computed expectations, then randomized traffic.
module tb_led_pwm_fader;
  localparam int PB   = 4;
  localparam int PS   = 4;
  localparam int FD   = 2;
  localparam int MAXL = 15;
  localparam int PER  = PS * 16;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [3:0] BRIGHT;
  logic       FADE_EN;
  logic [7:0] LED;
  logic       BUSY;

  led_pwm_fader_if pif();

  led_pwm_fader #(.PWM_BITS(PB), .PRESCALE(PS), .FADE_DIV(FD)) dut (
    .CLK(CLK), .RST_N(RST_N), .pat_if(pif), .BRIGHT(BRIGHT),
    .FADE_EN(FADE_EN), .LED(LED), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  // Model: time since reset, period index, per-LED integer levels.
  int       m_t, m_per;
  int       m_lvl [8];
  bit [7:0] m_tgt, m_pat;
  bit       m_pend, m_ready;

  always @(posedge CLK) begin : model
    bit [7:0] newt;
    bit       fw;
    if (!RST_N) begin
      m_t = 0; m_per = 0; m_tgt = 8'h00; m_pend = 1'b0; m_ready = 1'b0;
      for (int i = 0; i < 8; i++) m_lvl[i] = 0;
      chk_en = 1'b1;
    end else begin
      if ((m_t % PER) == PER - 1) begin
        newt = m_pend ? m_pat : m_tgt;
        fw = ((m_per % FD) == FD - 1);
        for (int i = 0; i < 8; i++) begin
          if (newt[i]) m_lvl[i] = int'(BRIGHT);
          else if (!FADE_EN) m_lvl[i] = 0;
          else if (fw && !m_tgt[i] && m_lvl[i] > 0) m_lvl[i] = m_lvl[i] - 1;
        end
        m_tgt = newt;
        m_pend = 1'b0;
        m_per = m_per + 1;
      end
      if (pif.PATTERN_VALID && m_ready) begin
        m_pend = 1'b1;
        m_pat = pif.PATTERN;
      end
      m_ready = !m_pend;
      m_t = m_t + 1;
    end
  end

  always @(negedge CLK) begin : compare
    logic [7:0] e_led;
    logic       e_busy;
    int         phase;
    if (chk_en) begin
      phase = (m_t / PS) % 16;
      e_busy = 1'b0;
      for (int i = 0; i < 8; i++) begin
        e_led[i] = (m_lvl[i] == MAXL) || (m_lvl[i] > phase);
        if (!m_tgt[i] && m_lvl[i] != 0) e_busy = 1'b1;
      end
      total = total + 3;
      if (LED !== e_led) begin
        bad = bad + 1;
        if (bad < 40) $display("FAIL model_led t=%0t got=%h exp=%h", $time, LED, e_led);
      end
      if (pif.PATTERN_READY !== m_ready) begin
        bad = bad + 1;
        if (bad < 40) $display("FAIL model_ready t=%0t got=%b exp=%b", $time, pif.PATTERN_READY, m_ready);
      end
      if (BUSY !== e_busy) begin
        bad = bad + 1;
        if (bad < 40) $display("FAIL model_busy t=%0t got=%b exp=%b", $time, BUSY, e_busy);
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    total = total + 1;
    if (got != exp) begin
      bad = bad + 1;
      $display("FAIL %s t=%0t got=%0d exp=%0d", name, $time, got, exp);
    end
  endtask

  int hcnt [8];
  int bcnt, diff07;

  task automatic measure();
    for (int i = 0; i < 8; i++) hcnt[i] = 0;
    bcnt = 0; diff07 = 0;
    repeat (PER) begin
      @(negedge CLK);
      for (int i = 0; i < 8; i++) hcnt[i] = hcnt[i] + int'(LED[i]);
      bcnt = bcnt + int'(BUSY);
      diff07 = diff07 + int'(LED[0] ^ LED[7]);
    end
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!pif.PATTERN_READY && n < 3 * PER) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 3 * PER) chk(name, 0, 1);
  endtask

  task automatic send(input logic [7:0] p);
    wait_ready("send_wait");
    pif.PATTERN = p;
    pif.PATTERN_VALID = 1'b1;
    @(negedge CLK);
    pif.PATTERN_VALID = 1'b0;
    chk("ready_drop", int'(pif.PATTERN_READY), 0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n, s;
    pif.PATTERN_VALID = 1'b1;
    pif.PATTERN = 8'hFF;
    BRIGHT = 4'd0;
    FADE_EN = 1'b0;
    RST_N = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      chk("rst_led", int'(LED), 0);
      chk("rst_ready", int'(pif.PATTERN_READY), 0);
    end
    RST_N = 1'b1;
    pif.PATTERN_VALID = 1'b0;
    @(negedge CLK);
    chk("rel_ready", int'(pif.PATTERN_READY), 1);
    chk("rel_led", int'(LED), 0);

    // full brightness on LED0 only
    BRIGHT = 4'd15;
    send(8'h01);
    wait_ready("apply01");
    measure();
    chk("full_on_led0", hcnt[0], PER);
    s = 0;
    for (int i = 1; i < 8; i++) s = s + hcnt[i];
    chk("others_off", s, 0);

    // half brightness on LED0 and LED7, in phase
    BRIGHT = 4'd8;
    send(8'h81);
    wait_ready("apply81");
    measure();
    chk("half_led0", hcnt[0], 32);
    chk("half_led7", hcnt[7], 32);
    chk("half_phase", diff07, 0);

    // fade LED0 out from 15
    BRIGHT = 4'd15;
    send(8'h01);
    wait_ready("apply01b");
    FADE_EN = 1'b1;
    send(8'h02);
    wait_ready("apply02");
    measure();
    chk("fade_hold_led0", hcnt[0], PER);
    chk("fade_busy", bcnt, PER);
    n = 0;
    while (BUSY && n < 40 * PER) begin
      @(negedge CLK);
      n++;
    end
    chk("fade_done", int'(BUSY), 0);
    measure();
    chk("faded_led0", hcnt[0], 0);
    chk("faded_led1", hcnt[1], PER);
    chk("faded_busy", bcnt, 0);

    // immediate off
    send(8'h01);
    wait_ready("apply01c");
    FADE_EN = 1'b0;
    send(8'h02);
    wait_ready("apply02b");
    measure();
    chk("cut_led0", hcnt[0], 0);
    chk("cut_busy", bcnt, 0);
    chk("cut_led1", hcnt[1], PER);

    // back-to-back offers with VALID held, zero brightness
    BRIGHT = 4'd0;
    wait_ready("b2b_wait");
    pif.PATTERN = 8'h04;
    pif.PATTERN_VALID = 1'b1;
    @(negedge CLK);
    pif.PATTERN = 8'h08;
    n = 0;
    while (!pif.PATTERN_READY && n < 3 * PER) begin
      @(negedge CLK);
      n++;
    end
    chk("b2b_held_low", int'(n > 0), 1);
    @(negedge CLK);
    pif.PATTERN_VALID = 1'b0;
    chk("b2b_ready_drop", int'(pif.PATTERN_READY), 0);
    wait_ready("apply08");
    measure();
    s = 0;
    for (int i = 0; i < 8; i++) s = s + hcnt[i];
    chk("bright0_dark", s, 0);

    // randomized traffic
    FADE_EN = 1'b1;
    BRIGHT = 4'd12;
    repeat (15000) begin
      @(negedge CLK);
      pif.PATTERN_VALID = ($urandom_range(0, 39) == 0);
      pif.PATTERN = 8'($urandom);
      if ($urandom_range(0, 299) == 0) BRIGHT = 4'($urandom);
      if ($urandom_range(0, 499) == 0) FADE_EN = ~FADE_EN;
      if ($urandom_range(0, 3999) == 0) begin
        RST_N = 1'b0;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
      end
    end
    pif.PATTERN_VALID = 1'b0;
    repeat (4) @(negedge CLK);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
